// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register.
// Holds WIDTH bits and supports hold, parallel load, logical shifts with serial
// inputs, rotates, arithmetic shift right and clear. Multi-bit shift and rotate
// commands advance one bit per clock behind a valid/ready command handshake.
module param_universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in_right,
    input  logic             s_in_left,
    output logic [WIDTH-1:0] data_out,
    output logic             s_out_right,
    output logic             s_out_left,
    output logic             busy,
    output logic             done
);

    // Operation codes
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SR   = 3'b001;
    localparam logic [2:0] OP_SL   = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_RR   = 3'b100;
    localparam logic [2:0] OP_RL   = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    // Controller states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             done_q,  done_d;

    // True for the operations that repeat cmd_amt one-bit steps.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SR) || (op == OP_SL) || (op == OP_RR) ||
               (op == OP_RL) || (op == OP_ASR);
    endfunction

    // One single-bit step of a shift/rotate operation; other codes hold.
    function automatic logic [WIDTH-1:0] step(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] q,
                                              input logic             sr,
                                              input logic             sl);
        logic [WIDTH-1:0] r;
        r = q;
        case (op)
            OP_SR:   r = {sr, q[WIDTH-1:1]};
            OP_SL:   r = {q[WIDTH-2:0], sl};
            OP_RR:   r = {q[0], q[WIDTH-1:1]};
            OP_RL:   r = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ASR:  r = {q[WIDTH-1], q[WIDTH-1:1]};
            default: r = q;
        endcase
        return r;
    endfunction

    // Next-state logic: command acceptance in IDLE, stepping in SHIFT.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (state_q == ST_SHIFT) begin
            // Serial inputs are sampled live on every step.
            data_d = step(op_q, data_q, s_in_right, s_in_left);
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (cmd_valid) begin
            // IDLE always presents cmd_ready, so valid alone means accept.
            if (is_shift_op(cmd_op)) begin
                if (cmd_amt != '0) begin
                    // First step happens on the accept edge itself.
                    data_d = step(cmd_op, data_q, s_in_right, s_in_left);
                end
                if (cmd_amt > CNT_W'(1)) begin
                    cnt_d   = cmd_amt - 1'b1;
                    op_d    = cmd_op;
                    state_d = ST_SHIFT;
                end else begin
                    done_d  = 1'b1;
                end
            end else begin
                if (cmd_op == OP_LOAD) begin
                    data_d = p_in;
                end else if (cmd_op == OP_CLR) begin
                    data_d = '0;
                end
                done_d = 1'b1;
            end
        end
    end

    // State registers; reset drops any command in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == ST_SHIFT);
    assign cmd_ready   = ~busy;
    assign done        = done_q;
    assign data_out    = data_q;
    assign s_out_right = data_q[0];
    assign s_out_left  = data_q[WIDTH-1];

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Bench for param_universal_shift_reg (WIDTH=8): directed scenarios followed
// by random commands, with a scoreboard queue fed by the stimulus side and
// drained by a monitor that reacts to done pulses.
module tb_param_universal_shift_reg;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] SR   = 3'd1;
    localparam logic [2:0] SL   = 3'd2;
    localparam logic [2:0] LOAD = 3'd3;
    localparam logic [2:0] RR   = 3'd4;
    localparam logic [2:0] RL   = 3'd5;
    localparam logic [2:0] ASR  = 3'd6;
    localparam logic [2:0] CLR  = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [W-1:0]     p_in;
    logic             s_in_right;
    logic             s_in_left;
    logic [W-1:0]     data_out;
    logic             s_out_right;
    logic             s_out_left;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q;

    param_universal_shift_reg #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_amt     (cmd_amt),
        .p_in        (p_in),
        .s_in_right  (s_in_right),
        .s_in_left   (s_in_left),
        .data_out    (data_out),
        .s_out_right (s_out_right),
        .s_out_left  (s_out_left),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Whole-command result computed arithmetically from the operation's
    // definition; serial inputs are held constant for the command's duration.
    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input int amt,
                                               input logic [W-1:0] q, input logic [W-1:0] p,
                                               input logic sr, input logic sl);
        int v, m, n, s, r;
        m = (1 << W) - 1;
        v = int'(q);
        n = amt % W;
        r = v;
        case (op)
            NOP:  r = v;
            SR:   if (amt >= W) r = sr ? m : 0;
                  else r = (v >> amt) | (sr ? (m & ~(m >> amt)) : 0);
            SL:   if (amt >= W) r = sl ? m : 0;
                  else r = ((v << amt) & m) | (sl ? ((1 << amt) - 1) : 0);
            LOAD: r = int'(p);
            RR:   r = ((v >> n) | (v << (W - n))) & m;
            RL:   r = ((v << n) | (v >> (W - n))) & m;
            ASR:  begin
                      s = q[W-1] ? v - (1 << W) : v;
                      r = (s >>> ((amt >= W) ? (W - 1) : amt)) & m;
                  end
            CLR:  r = 0;
            default: r = v;
        endcase
        return W'(r);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done_with_empty_queue data=0x%0h required=no_done", data_out);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("data_at_done", 32'(data_out), 32'(e));
                check("s_out_right", 32'(s_out_right), 32'(e[0]));
                check("s_out_left", 32'(s_out_left), 32'(e[W-1]));
                check("ready_at_done", 32'(cmd_ready), 32'd1);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=cmd_ready_low required=cmd_ready_high");
        end
    endtask

    // Issue one command; exp_ovr >= 0 supplies a literal expected result,
    // otherwise the reference model computes it.
    task automatic issue(input logic [2:0] op, input int amt, input logic [W-1:0] p,
                         input logic sr, input logic sl, input int exp_ovr);
        logic [W-1:0] e;
        wait_ready();
        cmd_op     = op;
        cmd_amt    = CNT_W'(amt);
        p_in       = p;
        s_in_right = sr;
        s_in_left  = sl;
        cmd_valid  = 1'b1;
        e = (exp_ovr >= 0) ? W'(exp_ovr) : ref_model(op, amt, model_q, p, sr, sl);
        exp_q.push_back(e);
        model_q = e;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] trace[2];
        int busy_cnt, nready_cnt, done_cnt;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = NOP;
        cmd_amt    = '0;
        p_in       = '0;
        s_in_right = 1'b0;
        s_in_left  = 1'b0;
        model_q    = '0;

        // Reset state
        @(negedge clk);
        check("reset_data", 32'(data_out), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Parallel load
        issue(LOAD, 0, 8'hA5, 1'b0, 1'b0, 'hA5);
        drain();

        // Multi-cycle shift right with serial ones
        issue(LOAD, 0, 8'h81, 1'b0, 1'b0, 'h81);
        issue(SR, 3, 8'h00, 1'b1, 1'b0, 'hF0);
        busy_cnt   = 0;
        nready_cnt = 0;
        trace[0]   = '0;
        trace[1]   = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 2) trace[k] = data_out;
            busy_cnt   += int'(busy);
            nready_cnt += int'(!cmd_ready);
            if (done) break;
        end
        check("sr_step1", 32'(trace[0]), 32'hC0);
        check("sr_step2", 32'(trace[1]), 32'hE0);
        check("sr_busy_cycles", 32'(busy_cnt), 32'd2);
        check("sr_not_ready_cycles", 32'(nready_cnt), 32'd2);
        drain();

        // Rotate, arithmetic shift, rotate by more than WIDTH
        issue(LOAD, 0, 8'hA5, 1'b0, 1'b0, 'hA5);
        issue(RL, 4, 8'h00, 1'b0, 1'b0, 'h5A);
        issue(LOAD, 0, 8'h90, 1'b0, 1'b0, 'h90);
        issue(ASR, 2, 8'h00, 1'b0, 1'b0, 'hE4);
        issue(LOAD, 0, 8'h3C, 1'b0, 1'b0, 'h3C);
        issue(RR, 9, 8'h00, 1'b0, 1'b0, 'h1E);
        drain();

        // Zero-amount shift, then a CLR attempted while busy
        issue(SL, 0, 8'h00, 1'b1, 1'b1, 'h1E);
        issue(LOAD, 0, 8'h3C, 1'b0, 1'b0, 'h3C);
        issue(RR, 5, 8'h00, 1'b0, 1'b0, 'hE1);
        check("busy_during_rr", 32'(busy), 32'd1);
        cmd_op    = CLR;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drain();

        // Reset in the middle of a long shift
        issue(LOAD, 0, 8'h5A, 1'b0, 1'b0, 'h5A);
        issue(SL, 6, 8'h00, 1'b1, 1'b1, -1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_q = '0;
        check("midreset_data", 32'(data_out), 32'h00);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset_ready", 32'(cmd_ready), 32'd1);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        check("post_reset_no_done", 32'(done_cnt), 32'd0);
        check("post_reset_data", 32'(data_out), 32'h00);
        @(posedge clk);
        #1;

        // Random commands against the reference model
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
                  W'($urandom), 1'($urandom), 1'($urandom), -1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
